// File: rtl/timed_vreg_bank.sv
`default_nettype none
// ============================================================================
// Module   : timed_vreg_bank
// Purpose  : Bank of verification-driven registers. Each channel can be set,
//            inverted or periodically toggled after a programmable number of
//            clock cycles. Each channel also reports one-cycle change pulses
//            and a saturating change count.
// Revision : 1.0 - initial release
// ============================================================================
module timed_vreg_bank #(
   parameter int               NUM_CH    = 4,
   parameter int               WIDTH     = 56,
   parameter int               DELAY_W   = 16,
   parameter int               CNT_W     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic [CH_W-1:0]           wr_ch,
   input  logic [1:0]                wr_mode,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic [DELAY_W-1:0]        wr_delay,
   output logic [NUM_CH*WIDTH-1:0]   vreg_out,
   output logic [NUM_CH-1:0]         pending,
   output logic [NUM_CH-1:0]         change_pulse,
   output logic [NUM_CH*CNT_W-1:0]   change_count,
   output logic                      err_pulse
);

   // Command encodings on wr_mode
   localparam logic [1:0] MODE_SET    = 2'b00;
   localparam logic [1:0] MODE_INVERT = 2'b01;
   localparam logic [1:0] MODE_PERIOD = 2'b10;
   localparam logic [1:0] MODE_CANCEL = 2'b11;

   // Per-channel FSM state encodings
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_PERIOD = 2'd2;

   // Channel count widened by one bit so it can be compared against wr_ch
   localparam logic [CH_W:0]      NUM_CH_EXT = (CH_W + 1)'(NUM_CH);
   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
   localparam logic [DELAY_W-1:0] TIMER_ONE  = DELAY_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

   logic w_ch_valid;
   logic r_err;

   // Out-of-range channels can only exist when NUM_CH is not a power of two
   assign w_ch_valid = ({1'b0, wr_ch} < NUM_CH_EXT);

   // Flag a command aimed at a non-existent channel one cycle later
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else begin
         r_err <= wr_en && !w_ch_valid;
      end
   end

   assign err_pulse = r_err;

   generate
      for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
         localparam logic [CH_W-1:0] CH_ID = CH_W'(n);

         // Armed-action state
         logic [1:0]         r_state;
         logic [1:0]         w_state_nxt;
         logic [DELAY_W-1:0] r_timer;
         logic [DELAY_W-1:0] w_timer_nxt;
         logic [DELAY_W-1:0] r_reload;
         logic [DELAY_W-1:0] w_reload_nxt;
         logic [WIDTH-1:0]   r_data;
         logic [WIDTH-1:0]   w_data_nxt;
         logic               r_invert;
         logic               w_invert_nxt;

         // Observable channel value and change reporting
         logic [WIDTH-1:0]   r_val;
         logic [WIDTH-1:0]   w_apply_val;
         logic               w_apply;
         logic               r_pulse;
         logic [CNT_W-1:0]   r_cnt;

         logic               w_cmd;
         logic               w_armed;
         logic               w_expire;

         // wr_ch can only equal CH_ID when it is in range, so no extra gating
         assign w_cmd    = wr_en && (wr_ch == CH_ID);
         assign w_armed  = (r_state == ST_WAIT) || (r_state == ST_PERIOD);
         assign w_expire = w_armed && (r_timer == '0);

         // State register: FSM state, countdown timer and latched command
         always_ff @(posedge clk) begin
            if (reset) begin
               r_state  <= ST_IDLE;
               r_timer  <= '0;
               r_reload <= '0;
               r_data   <= '0;
               r_invert <= 1'b0;
            end else begin
               r_state  <= w_state_nxt;
               r_timer  <= w_timer_nxt;
               r_reload <= w_reload_nxt;
               r_data   <= w_data_nxt;
               r_invert <= w_invert_nxt;
            end
         end

         // Next state: advance the armed action, then let a new command override
         always_comb begin
            w_state_nxt  = r_state;
            w_timer_nxt  = r_timer;
            w_reload_nxt = r_reload;
            w_data_nxt   = r_data;
            w_invert_nxt = r_invert;

            case (r_state)
               ST_WAIT: begin
                  if (r_timer == '0) begin
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_timer_nxt = r_timer - TIMER_ONE;
                  end
               end
               ST_PERIOD: begin
                  if (r_timer == '0) begin
                     w_timer_nxt = r_reload;
                  end else begin
                     w_timer_nxt = r_timer - TIMER_ONE;
                  end
               end
               default: begin
                  w_state_nxt = ST_IDLE;
               end
            endcase

            // A command lands after any expiry at this edge has been applied,
            // so its delay counts from this edge and the old action is gone
            if (w_cmd) begin
               case (wr_mode)
                  MODE_SET, MODE_INVERT: begin
                     w_state_nxt  = ST_WAIT;
                     w_timer_nxt  = wr_delay;
                     w_data_nxt   = wr_data;
                     w_invert_nxt = (wr_mode == MODE_INVERT);
                  end
                  MODE_PERIOD: begin
                     w_state_nxt  = ST_PERIOD;
                     w_timer_nxt  = wr_delay;
                     w_reload_nxt = wr_delay;
                     w_data_nxt   = wr_data;
                     w_invert_nxt = 1'b0;
                  end
                  MODE_CANCEL: begin
                     w_state_nxt = ST_IDLE;
                  end
                  default: begin
                     w_state_nxt = ST_IDLE;
                  end
               endcase
            end
         end

         // Output decode: value the channel takes when its action expires
         always_comb begin
            w_apply     = 1'b0;
            w_apply_val = r_val;
            if (w_expire) begin
               w_apply = 1'b1;
               if (r_state == ST_PERIOD) begin
                  w_apply_val = r_val ^ r_data;
               end else if (r_invert) begin
                  w_apply_val = ~r_val;
               end else begin
                  w_apply_val = r_data;
               end
            end
         end

         // Channel value with change pulse and saturating change counter;
         // an apply that rewrites the same value is not a change
         always_ff @(posedge clk) begin
            if (reset) begin
               r_val   <= RESET_VAL;
               r_pulse <= 1'b0;
               r_cnt   <= '0;
            end else if (w_apply && (w_apply_val != r_val)) begin
               r_val   <= w_apply_val;
               r_pulse <= 1'b1;
               if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end else begin
               r_pulse <= 1'b0;
            end
         end

         assign vreg_out[n*WIDTH +: WIDTH]     = r_val;
         assign pending[n]                     = w_armed;
         assign change_pulse[n]                = r_pulse;
         assign change_count[n*CNT_W +: CNT_W] = r_cnt;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_timed_vreg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_timed_vreg_bank
// Purpose  : Self-checking bench for timed_vreg_bank. Instance A uses the
//            default geometry; instance B is a small 3-channel, 2-bit bank
//            with 2-bit counters for saturation and out-of-range commands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timed_vreg_bank;

   localparam logic [1:0] M_SET = 2'b00;
   localparam logic [1:0] M_INV = 2'b01;
   localparam logic [1:0] M_PER = 2'b10;
   localparam logic [1:0] M_CAN = 2'b11;

   logic clk = 1'b0;
   logic reset;

   // Instance A: 4 channels x 56 bits, 8-bit counters
   logic         a_wr_en;
   logic [1:0]   a_wr_ch;
   logic [1:0]   a_wr_mode;
   logic [55:0]  a_wr_data;
   logic [15:0]  a_wr_delay;
   logic [223:0] a_vreg;
   logic [3:0]   a_pending;
   logic [3:0]   a_pulse;
   logic [31:0]  a_count;
   logic         a_err;

   // Instance B: 3 channels x 2 bits, 2-bit counters
   logic         b_wr_en;
   logic [1:0]   b_wr_ch;
   logic [1:0]   b_wr_mode;
   logic [1:0]   b_wr_data;
   logic [15:0]  b_wr_delay;
   logic [5:0]   b_vreg;
   logic [2:0]   b_pending;
   logic [2:0]   b_pulse;
   logic [5:0]   b_count;
   logic         b_err;

   timed_vreg_bank u_dut_a (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (a_wr_en),
      .wr_ch        (a_wr_ch),
      .wr_mode      (a_wr_mode),
      .wr_data      (a_wr_data),
      .wr_delay     (a_wr_delay),
      .vreg_out     (a_vreg),
      .pending      (a_pending),
      .change_pulse (a_pulse),
      .change_count (a_count),
      .err_pulse    (a_err)
   );

   timed_vreg_bank #(
      .NUM_CH    (3),
      .WIDTH     (2),
      .DELAY_W   (16),
      .CNT_W     (2),
      .RESET_VAL (2'b00)
   ) u_dut_b (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (b_wr_en),
      .wr_ch        (b_wr_ch),
      .wr_mode      (b_wr_mode),
      .wr_data      (b_wr_data),
      .wr_delay     (b_wr_delay),
      .vreg_out     (b_vreg),
      .pending      (b_pending),
      .change_pulse (b_pulse),
      .change_count (b_count),
      .err_pulse    (b_err)
   );

   always #5 clk = ~clk;

   // Edge counter: at a falling edge, cyc equals the number of rising edges so far
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Scoreboard entry: the value/count/pulse a channel must show after edge 'due'
   typedef struct {
      int          due;
      int          dut;
      int          ch;
      logic [55:0] val;
      int          cnt;
      bit          pulse;
   } exp_t;

   exp_t sb[$];

   exp_t        m_e;
   logic [55:0] m_val;
   int          m_cnt;
   logic        m_pulse;

   // Scoreboard consumer: compares each expectation on the falling edge it falls due
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         m_e = sb.pop_front();
         if (m_e.dut == 0) begin
            m_val   = a_vreg[m_e.ch*56 +: 56];
            m_cnt   = int'(a_count[m_e.ch*8 +: 8]);
            m_pulse = a_pulse[m_e.ch];
         end else begin
            m_val   = {54'd0, b_vreg[m_e.ch*2 +: 2]};
            m_cnt   = int'(b_count[m_e.ch*2 +: 2]);
            m_pulse = b_pulse[m_e.ch];
         end
         checks++;
         if (m_e.due != cyc || m_val !== m_e.val || m_cnt != m_e.cnt || m_pulse !== m_e.pulse) begin
            errors++;
            $display("FAIL sb dut%0d ch%0d at edge %0d (due %0d): got val=%h cnt=%0d pulse=%b, want val=%h cnt=%0d pulse=%b",
                     m_e.dut, m_e.ch, cyc, m_e.due, m_val, m_cnt, m_pulse, m_e.val, m_e.cnt, m_e.pulse);
         end
      end
   end

   // Drive one command on A at a falling edge; it is sampled at the next rising edge
   task automatic cmd_a(input int ch, input logic [1:0] mode, input logic [55:0] data, input int dly);
      a_wr_en    = 1'b1;
      a_wr_ch    = 2'(ch);
      a_wr_mode  = mode;
      a_wr_data  = data;
      a_wr_delay = 16'(dly);
      @(negedge clk);
      a_wr_en    = 1'b0;
   endtask

   task automatic cmd_b(input int ch, input logic [1:0] mode, input logic [1:0] data, input int dly);
      b_wr_en    = 1'b1;
      b_wr_ch    = 2'(ch);
      b_wr_mode  = mode;
      b_wr_data  = data;
      b_wr_delay = 16'(dly);
      @(negedge clk);
      b_wr_en    = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      cmd_a(0, M_SET, 56'hFF_FFFF, 0);
      cmd_b(0, M_SET, 2'b11, 0);
      reset = 1'b0;
      checks++;
      if (a_vreg !== '0 || a_pending !== '0 || a_pulse !== '0 || a_count !== '0 || a_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_a: vreg=%h pend=%b pulse=%b cnt=%h err=%b, want all zero", a_vreg, a_pending, a_pulse, a_count, a_err);
      end
      checks++;
      if (b_vreg !== '0 || b_pending !== '0 || b_pulse !== '0 || b_count !== '0 || b_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_b: vreg=%h pend=%b pulse=%b cnt=%h err=%b, want all zero", b_vreg, b_pending, b_pulse, b_count, b_err);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (a_vreg !== '0 || a_pending !== '0 || b_vreg !== '0 || b_pending !== '0) begin
         errors++;
         $display("FAIL reset_cmd_ignored: a_vreg=%h a_pend=%b b_vreg=%h b_pend=%b, want zero", a_vreg, a_pending, b_vreg, b_pending);
      end
   endtask

   task automatic test_set();
      int k;
      k = cyc + 1;
      sb.push_back('{k + 1, 0, 0, 56'h234567891200, 1, 1'b1});
      cmd_a(0, M_SET, 56'h234567891200, 0);
      checks++;
      if (a_pending[0] !== 1'b1) begin
         errors++;
         $display("FAIL set_pending_wait: got %b want 1", a_pending[0]);
      end
      @(negedge clk);
      checks++;
      if (a_pending[0] !== 1'b0) begin
         errors++;
         $display("FAIL set_pending_done: got %b want 0", a_pending[0]);
      end
      @(negedge clk);
      checks++;
      if (a_pulse[0] !== 1'b0 || a_count[7:0] !== 8'd1) begin
         errors++;
         $display("FAIL set_pulse_one_cycle: pulse=%b cnt=%0d want 0 and 1", a_pulse[0], a_count[7:0]);
      end
   endtask

   task automatic test_invert();
      int k;
      k = cyc + 1;
      sb.push_back('{k + 10, 1, 1, 56'h3, 1, 1'b1});
      cmd_b(1, M_INV, 2'b00, 9);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (b_pending[1] !== 1'b1 || b_vreg[3:2] !== 2'b00) begin
            errors++;
            $display("FAIL invert_wait[%0d]: pend=%b val=%b want 1 and 00", i, b_pending[1], b_vreg[3:2]);
         end
         @(negedge clk);
      end
      checks++;
      if (b_pending[1] !== 1'b0) begin
         errors++;
         $display("FAIL invert_pending_done: got %b want 0", b_pending[1]);
      end
   endtask

   task automatic test_periodic();
      int k;
      k = cyc + 1;
      for (int i = 1; i <= 5; i++) begin
         sb.push_back('{k + 10*i, 0, 2, 56'(i % 2), i, 1'b1});
      end
      cmd_a(2, M_PER, 56'h1, 9);
      repeat (50) @(negedge clk);
      checks++;
      if (a_pending[2] !== 1'b1 || a_count[23:16] !== 8'd5) begin
         errors++;
         $display("FAIL periodic_armed: pend=%b cnt=%0d want 1 and 5", a_pending[2], a_count[23:16]);
      end
      cmd_a(2, M_CAN, 56'h0, 0);
      checks++;
      if (a_pending[2] !== 1'b0) begin
         errors++;
         $display("FAIL periodic_cancel_pending: got %b want 0", a_pending[2]);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (a_vreg[167:112] !== 56'h1 || a_count[23:16] !== 8'd5 || a_pulse[2] !== 1'b0) begin
         errors++;
         $display("FAIL periodic_hold: val=%h cnt=%0d pulse=%b want 1, 5, 0", a_vreg[167:112], a_count[23:16], a_pulse[2]);
      end
   endtask

   task automatic test_replace();
      int k;
      int j;
      int m;
      logic [55:0] v1;
      logic [55:0] v2;
      logic [55:0] v3;
      logic [55:0] v4;
      logic [55:0] v5;
      v1 = 56'h00AA_55AA_55AA_5500;
      v2 = 56'h12_3456_789A_BCDE;
      v3 = 56'hF0_0000_0000_000F;
      v4 = 56'h0F_0F0F_0F0F_0F0F;
      v5 = 56'hDE_ADBE_EF00_0001;

      // Second command replaces the first before it fires
      k = cyc + 1;
      cmd_a(3, M_SET, v1, 5);
      @(negedge clk);
      sb.push_back('{k + 3, 0, 3, v2, 1, 1'b1});
      cmd_a(3, M_SET, v2, 0);
      repeat (6) @(negedge clk);
      checks++;
      if (a_vreg[223:168] !== v2 || a_count[31:24] !== 8'd1 || a_pending[3] !== 1'b0) begin
         errors++;
         $display("FAIL replace_old_never_fires: val=%h cnt=%0d pend=%b want %h, 1, 0", a_vreg[223:168], a_count[31:24], a_pending[3], v2);
      end

      // Expiry and new command on the same edge: old applies, new is loaded
      j = cyc + 1;
      sb.push_back('{j + 3, 0, 3, v3, 2, 1'b1});
      cmd_a(3, M_SET, v3, 2);
      @(negedge clk);
      sb.push_back('{j + 5, 0, 3, v4, 3, 1'b1});
      @(negedge clk);
      cmd_a(3, M_SET, v4, 1);
      checks++;
      if (a_pending[3] !== 1'b1) begin
         errors++;
         $display("FAIL same_edge_new_armed: got %b want 1", a_pending[3]);
      end
      repeat (3) @(negedge clk);

      // CANCEL landing on the expiry edge still lets the apply happen
      m = cyc + 1;
      sb.push_back('{m + 2, 0, 0, v5, 2, 1'b1});
      cmd_a(0, M_SET, v5, 1);
      @(negedge clk);
      cmd_a(0, M_CAN, 56'h0, 0);
      checks++;
      if (a_pending[0] !== 1'b0) begin
         errors++;
         $display("FAIL cancel_at_expiry_pending: got %b want 0", a_pending[0]);
      end
      @(negedge clk);
   endtask

   task automatic test_saturate();
      int k;
      k = cyc + 1;
      for (int i = 1; i <= 10; i++) begin
         sb.push_back('{k + i, 1, 2, 56'(i % 2), (i < 3) ? i : 3, 1'b1});
      end
      cmd_b(2, M_PER, 2'b01, 0);
      repeat (9) @(negedge clk);
      cmd_b(2, M_CAN, 2'b00, 0);
      checks++;
      if (b_pending[2] !== 1'b0) begin
         errors++;
         $display("FAIL saturate_cancel_pending: got %b want 0", b_pending[2]);
      end
      @(negedge clk);
      checks++;
      if (b_vreg[5:4] !== 2'b00 || b_pulse[2] !== 1'b0 || b_count[5:4] !== 2'd3) begin
         errors++;
         $display("FAIL saturate_hold: val=%b pulse=%b cnt=%0d want 00, 0, 3", b_vreg[5:4], b_pulse[2], b_count[5:4]);
      end

      // Rewriting the current value is not a change
      k = cyc + 1;
      sb.push_back('{k + 1, 1, 0, 56'h0, 0, 1'b0});
      cmd_b(0, M_SET, 2'b00, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_err();
      logic [5:0] snap_vreg;
      logic [5:0] snap_cnt;
      snap_vreg = b_vreg;
      snap_cnt  = b_count;
      cmd_b(3, M_SET, 2'b10, 0);
      checks++;
      if (b_err !== 1'b1 || b_pending !== 3'b000 || a_err !== 1'b0) begin
         errors++;
         $display("FAIL err_pulse_high: b_err=%b b_pend=%b a_err=%b want 1, 000, 0", b_err, b_pending, a_err);
      end
      @(negedge clk);
      checks++;
      if (b_err !== 1'b0 || b_vreg !== snap_vreg || b_count !== snap_cnt || b_pending !== 3'b000) begin
         errors++;
         $display("FAIL err_no_state_change: err=%b vreg=%b cnt=%h pend=%b want 0, %b, %h, 000", b_err, b_vreg, b_count, b_pending, snap_vreg, snap_cnt);
      end
   endtask

   task automatic test_reset_mid();
      cmd_a(1, M_SET, 56'hFFFF, 20);
      cmd_a(2, M_PER, 56'hFF, 3);
      cmd_b(1, M_INV, 2'b00, 15);
      repeat (6) @(negedge clk);
      checks++;
      if (a_pending[2:1] !== 2'b11 || b_pending[1] !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_armed: a_pend=%b b_pend=%b want 11 and 1", a_pending[2:1], b_pending[1]);
      end
      reset = 1'b1;
      cmd_a(3, M_SET, 56'h5, 0);
      reset = 1'b0;
      checks++;
      if (a_vreg !== '0 || a_pending !== '0 || a_count !== '0 || a_pulse !== '0) begin
         errors++;
         $display("FAIL reset_mid_a: vreg=%h pend=%b cnt=%h pulse=%b want zero", a_vreg, a_pending, a_count, a_pulse);
      end
      checks++;
      if (b_vreg !== '0 || b_pending !== '0 || b_count !== '0) begin
         errors++;
         $display("FAIL reset_mid_b: vreg=%b pend=%b cnt=%h want zero", b_vreg, b_pending, b_count);
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         checks++;
         if (a_vreg !== '0 || a_pending !== '0 || a_count !== '0 || b_vreg !== '0) begin
            errors++;
            $display("FAIL reset_no_late_apply[%0d]: a_vreg=%h a_pend=%b a_cnt=%h b_vreg=%b want zero", i, a_vreg, a_pending, a_count, b_vreg);
         end
      end
   endtask

   // Bound the whole run so a stuck simulation still reports
   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit at edge %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   // Test sequence
   initial begin
      reset      = 1'b1;
      a_wr_en    = 1'b0;
      a_wr_ch    = '0;
      a_wr_mode  = '0;
      a_wr_data  = '0;
      a_wr_delay = '0;
      b_wr_en    = 1'b0;
      b_wr_ch    = '0;
      b_wr_mode  = '0;
      b_wr_data  = '0;
      b_wr_delay = '0;
      @(negedge clk);

      test_reset();
      test_set();
      test_invert();
      test_periodic();
      test_replace();
      test_saturate();
      test_err();
      test_reset_mid();

      while (sb.size() > 0) begin
         m_e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL sb_unconsumed: dut%0d ch%0d due %0d never compared", m_e.dut, m_e.ch, m_e.due);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
